spi_serf: RTL and testbench

//  SPI responder (serf) matching our SPI monarch: mode 3 (SCLK idles high, data driven on fall, sampled on rise),
//  MSB first, one WIDTH-bit word per SS_n-low frame. Full-duplex: shifts in MOSI while shifting out a preloaded

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync3.sv | 30 +++
 rtl/spi_serf.sv | 135 +++++++++++++
 tb/tb_spi_serf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI serf.
//   spi_serf_state_t : frame state (IDLE between frames, XFER while SS_n is low)
//   SPI_WIDTH        : default word length in bits
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } spi_serf_state_t;

endpackage

// File: rtl/spi_sync3.sv
// Three-flop synchronizer for one asynchronous input.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   s2, s3     : second and third stages; edges are decoded from this pair
module spi_sync3 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s2,
  output logic s3
);

  logic s1;

  // Chain resets to RST_VAL so an idle line produces no false edge at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

endmodule

// File: rtl/spi_serf.sv
// SPI mode-3 responder, MSB first, one WIDTH-bit word per SS_n-low frame.
//   clk, rst_n        : system clock, async active-low reset
//   SS_n, SCLK, MOSI  : asynchronous SPI inputs from the monarch
//   MISO, MISO_oe     : serial response and its output enable (MISO is 0 when disabled)
//   ld, tx_data       : load the response word used by the next frame
//   rx_data, rdy      : last good received word and its sticky valid flag
//   clr_rdy           : clears rdy
//   overrun           : pulse, good frame completed while rdy was still set
//   frame_err         : pulse, frame ended with a bit count other than WIDTH
module spi_serf
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_oe,
  input  logic             ld,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  input  logic             clr_rdy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  logic ss_s2, ss_s3, sclk_s2, sclk_s3, mosi_s2_unused, mosi_s3;

  spi_sync3 #(.RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst_n(rst_n), .d(SS_n), .s2(ss_s2),   .s3(ss_s3));
  spi_sync3 #(.RST_VAL(1'b1)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(SCLK), .s2(sclk_s2), .s3(sclk_s3));
  spi_sync3 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(MOSI), .s2(mosi_s2_unused), .s3(mosi_s3));

  logic ss_fall, ss_rise, sclk_rise;
  assign ss_fall   = ~ss_s2 & ss_s3;
  assign ss_rise   = ss_s2 & ~ss_s3;
  assign sclk_rise = sclk_s2 & ~sclk_s3;

  spi_serf_state_t  state, state_nxt;
  logic [WIDTH-1:0] tx_buf, tx_buf_nxt;
  logic [WIDTH-1:0] shft_reg, shft_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic [WIDTH-1:0] rx_nxt;
  logic             rdy_nxt, set_rdy, overrun_nxt, frame_err_nxt;
  logic             miso_nxt, oe_nxt;
  logic [1:0]       settle, settle_nxt;
  logic             armed, armed_nxt;

  // The SS_n chain resets high, so an SS_n already low at reset release would
  // look like a fall. Only honour falls once the chain has refilled from the
  // pin and SS_n has genuinely been seen high.
  always_comb begin
    settle_nxt = (settle == 2'd3) ? settle : settle + 2'd1;
    armed_nxt  = armed | ((settle == 2'd3) & ss_s3);
  end

  // Next-state and datapath decode.
  always_comb begin
    state_nxt     = state;
    tx_buf_nxt    = ld ? tx_data : tx_buf;
    shft_nxt      = shft_reg;
    cnt_nxt       = bit_cnt;
    rx_nxt        = rx_data;
    set_rdy       = 1'b0;
    overrun_nxt   = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall && armed) begin
          state_nxt = XFER;
          shft_nxt  = ld ? tx_data : tx_buf;
          cnt_nxt   = '0;
        end
      end
      XFER: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          if (bit_cnt == CNT_W'(WIDTH)) begin
            rx_nxt      = shft_reg;
            set_rdy     = 1'b1;
            overrun_nxt = rdy;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end else if (sclk_rise) begin
          shft_nxt = {shft_reg[WIDTH-2:0], mosi_s3};
          if (bit_cnt != CNT_W'(WIDTH + 1)) begin
            cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    rdy_nxt  = set_rdy | (rdy & ~clr_rdy);
    oe_nxt   = (state_nxt == XFER);
    miso_nxt = shft_nxt[WIDTH-1] & oe_nxt;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_buf    <= '0;
      shft_reg  <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      MISO      <= 1'b0;
      MISO_oe   <= 1'b0;
      settle    <= 2'd0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_buf    <= tx_buf_nxt;
      shft_reg  <= shft_nxt;
      bit_cnt   <= cnt_nxt;
      rx_data   <= rx_nxt;
      rdy       <= rdy_nxt;
      overrun   <= overrun_nxt;
      frame_err <= frame_err_nxt;
      MISO      <= miso_nxt;
      MISO_oe   <= oe_nxt;
      settle    <= settle_nxt;
      armed     <= armed_nxt;
    end
  end

endmodule

// File: tb/tb_spi_serf.sv
// Bench for spi_serf: a mode-3 monarch model plus a frame-level expectation
// model compared against the DUT outputs on every falling clock edge.
module tb_spi_serf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0;
  logic        ld = 1'b0, clr_rdy = 1'b0;
  logic [15:0] tx_data = '0;
  logic        MISO, MISO_oe, rdy, overrun, frame_err;
  logic [15:0] rx_data;

  spi_serf #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .ld(ld), .tx_data(tx_data),
    .rx_data(rx_data), .rdy(rdy), .clr_rdy(clr_rdy),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected outputs and frame-level model state.
  logic [15:0] exp_rx = '0;
  logic        exp_rdy = 1'b0, exp_ovr = 1'b0, exp_ferr = 1'b0, exp_oe = 1'b0;
  logic        m_active = 1'b0, m_armed = 1'b0;
  int          m_bits = 0;
  logic [15:0] m_sh = '0, m_txbuf = '0, exp_resp = '0;
  int          ovr_cnt = 0, ferr_cnt = 0;
  bit          oe_seen = 1'b0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare of every observable output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_data", 32'(rx_data), 32'(exp_rx));
      check("rdy", 32'(rdy), 32'(exp_rdy));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      check("frame_err", 32'(frame_err), 32'(exp_ferr));
      check("MISO_oe", 32'(MISO_oe), 32'(exp_oe));
      if (!exp_oe) check("miso_idle", 32'(MISO), 32'd0);
      if (overrun === 1'b1) ovr_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
      if (MISO_oe === 1'b1) oe_seen = 1'b1;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] w);
    ld = 1'b1; tx_data = w;
    @(posedge clk);
    m_txbuf = w;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic clr();
    clr_rdy = 1'b1;
    @(posedge clk);
    exp_rdy = 1'b0;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  // Frame start: outputs react three clocks after the pin changes.
  task automatic ss_low();
    SS_n = 1'b0;
    repeat (3) @(posedge clk);
    if (m_armed) begin
      m_active = 1'b1; m_bits = 0; exp_oe = 1'b1; exp_resp = m_txbuf;
    end
    wait_neg(16);
  endtask

  // Drive n SCLK cycles: MOSI changes on fall, MISO sampled at rise.
  task automatic sclk_bits(input logic [15:0] w, input int n, output logic [15:0] got);
    logic b;
    got = '0;
    for (int i = 0; i < n; i++) begin
      if (i < 16) b = w[15-i]; else b = 1'b0;
      SCLK = 1'b0; MOSI = b;
      wait_neg(16);
      got  = {got[14:0], MISO};
      SCLK = 1'b1;
      if (m_active) begin
        m_bits++;
        m_sh = {m_sh[14:0], b};
      end
      wait_neg(16);
    end
  endtask

  task automatic ss_high();
    SS_n = 1'b1;
    repeat (3) @(posedge clk);
    if (m_active) begin
      if (m_bits == 16) begin
        exp_ovr = exp_rdy; exp_rx = m_sh; exp_rdy = 1'b1;
      end else begin
        exp_ferr = 1'b1;
      end
      m_active = 1'b0; exp_oe = 1'b0;
    end
    m_armed = 1'b1;
    @(posedge clk);
    exp_ovr = 1'b0; exp_ferr = 1'b0;
    wait_neg(20);
  endtask

  task automatic frame(input logic [15:0] w, input int n, output logic [15:0] got);
    ss_low();
    sclk_bits(w, n, got);
    ss_high();
  endtask

  // Reset is asserted mid high-phase so the negedge compare sees a settled DUT.
  task automatic do_reset(input logic ss_val);
    @(posedge clk); #2;
    rst_n = 1'b0; SS_n = ss_val; SCLK = 1'b1; MOSI = 1'b0; ld = 1'b0; clr_rdy = 1'b0;
    exp_rx = '0; exp_rdy = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0; exp_oe = 1'b0;
    m_active = 1'b0; m_bits = 0; m_txbuf = '0;
    wait_neg(4);
    rst_n = 1'b1;
    m_armed = ss_val;
    wait_neg(10);
  endtask

  logic [15:0] got, g1, g2;
  int f0;

  initial begin
    chk_en = 1'b1;
    do_reset(1'b1);
    check("reset_rx", 32'(rx_data), 32'h0);
    check("reset_oe", 32'(MISO_oe), 32'h0);
    check("reset_rdy", 32'(rdy), 32'h0);

    // 1: basic full-duplex frame
    load(16'hA5C3);
    frame(16'h1234, 16, got);
    check("t1_miso_word", 32'(got), 32'hA5C3);
    check("t1_rx", 32'(rx_data), 32'h1234);
    check("t1_rdy", 32'(rdy), 32'h1);
    check("t1_resp_model", 32'(exp_resp), 32'hA5C3);

    // 2: overrun with rdy still set, then clear
    load(16'h5A5A);
    frame(16'hBEEF, 16, got);
    check("t2_ovr_cnt", 32'(ovr_cnt), 32'd1);
    check("t2_rx", 32'(rx_data), 32'hBEEF);
    check("t2_miso_word", 32'(got), 32'h5A5A);
    clr();
    check("t2_rdy_clr", 32'(rdy), 32'h0);

    // 3: short and long frames
    f0 = ferr_cnt;
    frame(16'h1111, 15, got);
    frame(16'h2222, 17, got);
    check("t3_ferr_cnt", 32'(ferr_cnt - f0), 32'd2);
    check("t3_rx", 32'(rx_data), 32'hBEEF);
    check("t3_rdy", 32'(rdy), 32'h0);

    // 4: load mid-frame only affects the next frame
    load(16'hFFFF);
    ss_low();
    sclk_bits(16'hC3A5, 8, g1);
    load(16'h0F0F);
    sclk_bits(16'hA500, 8, g2);
    ss_high();
    check("t4_resp1", 32'({g1[7:0], g2[7:0]}), 32'hFFFF);
    check("t4_rx1", 32'(rx_data), 32'hC3A5);
    frame(16'h0001, 16, got);
    check("t4_resp2", 32'(got), 32'h0F0F);
    check("t4_rx2", 32'(rx_data), 32'h0001);

    // 5: reset in the middle of a frame
    load(16'h8001);
    ss_low();
    sclk_bits(16'h7E00, 8, g1);
    do_reset(1'b0);
    check("t5_rx", 32'(rx_data), 32'h0);
    check("t5_rdy", 32'(rdy), 32'h0);
    check("t5_oe", 32'(MISO_oe), 32'h0);
    check("t5_miso", 32'(MISO), 32'h0);
    ss_high();
    load(16'h6C39);
    frame(16'h9AB1, 16, got);
    check("t5_miso_word", 32'(got), 32'h6C39);
    check("t5_rx_after", 32'(rx_data), 32'h9AB1);
    check("t5_rdy_after", 32'(rdy), 32'h1);

    // 6: SS_n already low at reset release must not start a frame
    do_reset(1'b0);
    f0 = ferr_cnt;
    oe_seen = 1'b0;
    sclk_bits(16'hFFFF, 16, got);
    ss_high();
    check("t6_rdy", 32'(rdy), 32'h0);
    check("t6_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t6_oe_seen", 32'(oe_seen), 32'h0);
    check("t6_rx", 32'(rx_data), 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
